// File: rtl/ahb_apb_bridge_pkg.sv
// Shared types and constants for the AHB-Lite to APB3 bridge.
package ahb_apb_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_SETUP,
      ST_ACCESS,
      ST_ERR1,
      ST_ERR2
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v))
         r++;
      return r;
   endfunction

   // Width of a field that must hold at least one bit.
   function automatic int unsigned min1_clog2(input int unsigned v);
      return (clog2(v) < 1) ? 1 : clog2(v);
   endfunction

endpackage

// File: rtl/ahb_apb_bridge_gen_apb_slot_decode.sv
// Combinational HADDR slot decoder: one-hot select plus unmapped flag.
module apb_slot_decode
   import ahb_apb_bridge_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned NUM_SLOTS  = 16,
   parameter int unsigned SLOT_LSB   = 24
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [NUM_SLOTS-1:0]  sel,
   output logic                  unmapped
);

   localparam int unsigned SEL_W = min1_clog2(NUM_SLOTS);

   logic [SEL_W-1:0] idx;
   logic             unused_addr;

   assign idx         = addr[SLOT_LSB+SEL_W-1:SLOT_LSB];
   assign unused_addr = ^addr;

   always_comb begin
      sel      = '0;
      unmapped = (32'(idx) >= NUM_SLOTS);
      for (int unsigned i = 0; i < NUM_SLOTS; i++)
         sel[i] = (32'(idx) == i);
   end

endmodule

// File: rtl/ahb_apb_bridge_gen.sv
// AHB-Lite slave to APB3 master bridge with wait states, slave errors,
// unmapped-slot detection and an ACCESS-phase timeout.
module ahb_apb_bridge_gen
   import ahb_apb_bridge_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned NUM_SLOTS      = 16,
   parameter int unsigned SLOT_LSB       = 24,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic                  HWRITE,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADYIN,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic [NUM_SLOTS-1:0]  PSEL,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PWRITE,
   output logic                  PENABLE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR,
   output logic                  ERR_SLV,
   output logic                  ERR_TMO
);

   localparam int unsigned TMO_W = min1_clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : TMO_W'(TIMEOUT_CYCLES - 1);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    write_q;
   logic [2:0]              hsize_q;
   logic [NUM_SLOTS-1:0]    slot_q;
   logic [TMO_W-1:0]        tmo_cnt;
   logic [NUM_SLOTS-1:0]    dec_sel;
   logic                    dec_unmapped;
   logic                    accept;
   logic                    unused_hsize;

   apb_slot_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_SLOTS  (NUM_SLOTS),
      .SLOT_LSB   (SLOT_LSB)
   ) u_decode (
      .addr     (HADDR),
      .sel      (dec_sel),
      .unmapped (dec_unmapped)
   );

   assign accept       = HSEL & HREADYIN & HTRANS[1];
   assign unused_hsize = ^hsize_q;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state     <= ST_IDLE;
         HREADYOUT <= 1'b1;
         HRESP     <= HRESP_OKAY;
         HRDATA    <= '0;
         PSEL      <= '0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         ERR_SLV   <= 1'b0;
         ERR_TMO   <= 1'b0;
         tmo_cnt   <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         hsize_q   <= '0;
         slot_q    <= '0;
      end else begin
         ERR_SLV <= 1'b0;
         ERR_TMO <= 1'b0;
         unique case (state)
            // ERR2 doubles as an idle slot: its final cycle may take a new address phase.
            ST_IDLE, ST_ERR2: begin
               if (accept) begin
                  addr_q    <= HADDR;
                  write_q   <= HWRITE;
                  hsize_q   <= HSIZE;
                  slot_q    <= dec_sel;
                  HREADYOUT <= 1'b0;
                  if (dec_unmapped) begin
                     state   <= ST_ERR1;
                     HRESP   <= HRESP_ERROR;
                     ERR_SLV <= 1'b1;
                  end else begin
                     state   <= ST_LATCH;
                     HRESP   <= HRESP_OKAY;
                  end
               end else begin
                  state     <= ST_IDLE;
                  HREADYOUT <= 1'b1;
                  HRESP     <= HRESP_OKAY;
               end
            end
            ST_LATCH: begin
               if (write_q)
                  PWDATA <= HWDATA;
               PSEL    <= slot_q;
               PADDR   <= addr_q;
               PWRITE  <= write_q;
               tmo_cnt <= '0;
               state   <= ST_SETUP;
            end
            ST_SETUP: begin
               PENABLE <= 1'b1;
               state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               tmo_cnt <= tmo_cnt + TMO_W'(1);
               if (PREADY) begin
                  PSEL    <= '0;
                  PENABLE <= 1'b0;
                  if (PSLVERR) begin
                     ERR_SLV <= 1'b1;
                     HRESP   <= HRESP_ERROR;
                     state   <= ST_ERR1;
                  end else begin
                     if (!PWRITE)
                        HRDATA <= PRDATA;
                     HREADYOUT <= 1'b1;
                     state     <= ST_IDLE;
                  end
               end else if (TIMEOUT_CYCLES != 0 && tmo_cnt == TMO_LAST) begin
                  PSEL    <= '0;
                  PENABLE <= 1'b0;
                  ERR_TMO <= 1'b1;
                  HRESP   <= HRESP_ERROR;
                  state   <= ST_ERR1;
               end
            end
            ST_ERR1: begin
               HRESP     <= HRESP_ERROR;
               HREADYOUT <= 1'b1;
               state     <= ST_ERR2;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/ahb_apb_bridge_gen.md
Name: ahb_apb_bridge_gen

Overview:
- Parametrised AHB-Lite slave to APB3 master bridge; successor of the fixed 16-slot, no-timeout bridge used behind the APB BFM.
- Sits between an AHB-Lite master (BFM or CPU fabric) and up to NUM_SLOTS APB peripherals.
- Adds configurable slot count and decode position, PREADY wait states, and PSLVERR mapped to a two-cycle AHB ERROR response.
- Also adds an ACCESS-phase timeout and unmapped-slot error detection.

Parameters:
- ADDR_WIDTH, 32, HADDR/PADDR width.
- DATA_WIDTH, 32, HWDATA/HRDATA/PWDATA/PRDATA width.
- NUM_SLOTS, 16, number of PSEL outputs (1..32).
- SLOT_LSB, 24, lowest HADDR bit of the slot index. The index occupies SEL_W = max(1, clog2(NUM_SLOTS)) bits.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before forced error; 0 disables the timeout.

Ports:
- HCLK  in  1  single clock for the AHB and APB sides.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  bridge select.
- HADDR  in  ADDR_WIDTH  address.
- HWRITE  in  1  write=1.
- HTRANS  in  2  transfer type.
- HSIZE  in  3  captured, not used.
- HWDATA  in  DATA_WIDTH  write data.
- HREADYIN  in  1  bus ready.
- HREADYOUT  out  1  bridge ready.
- HRESP  out  1  1=ERROR.
- HRDATA  out  DATA_WIDTH  read data.
- PSEL  out  NUM_SLOTS  one-hot slot select.
- PADDR  out  ADDR_WIDTH  APB address.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB enable.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.
- ERR_SLV  out  1  one-cycle pulse on PSLVERR or unmapped-slot error.
- ERR_TMO  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset values (asynchronous on HRESET=1):
  - state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
  - ERR_SLV=0, ERR_TMO=0, timeout counter=0.
- Reset mid-transfer abandons it immediately; no APB completion is owed.
- Accept condition: HSEL & HREADYIN & HTRANS[1] (NONSEQ/SEQ) while state is IDLE or ERR2. HADDR and HWRITE are registered at that edge. IDLE/BUSY transfers get an OKAY zero-wait response.
- Slot index = HADDR[SLOT_LSB+SEL_W-1:SLOT_LSB]; if index >= NUM_SLOTS the transfer is unmapped.
- States (all outputs registered):
  - IDLE: HREADYOUT=1, HRESP=0.
    - Mapped accept -> LATCH.
    - Unmapped accept -> ERR1 with ERR_SLV pulse; no APB activity.
  - LATCH: HREADYOUT=0; PWDATA<=HWDATA (write) or unchanged (read). -> SETUP.
  - SETUP: PSEL[index]=1, PENABLE=0, PADDR/PWRITE valid. -> ACCESS.
  - ACCESS: PSEL held, PENABLE=1; counter increments each cycle.
    - PREADY & !PSLVERR: HRDATA<=PRDATA (reads; writes leave HRDATA unchanged), PSEL/PENABLE<=0, -> IDLE.
    - PREADY & PSLVERR: PSEL/PENABLE<=0, ERR_SLV pulse, -> ERR1.
    - !PREADY with counter == TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES != 0): PSEL/PENABLE<=0, ERR_TMO pulse, -> ERR1.
  - ERR1: HRESP=1, HREADYOUT=0. -> ERR2.
  - ERR2: HRESP=1, HREADYOUT=1. -> IDLE, or LATCH/ERR1 if a new transfer is accepted this cycle.
- Latency: a transfer accepted at edge N is completed by a PREADY=1 sampled in ACCESS at edge N+3. HREADYOUT=1 (OKAY) appears in cycle N+4. Each PREADY=0 cycle adds one.
- Back-to-back: the IDLE cycle that completes one data phase may accept the next address phase.
- PSEL is never asserted for an unmapped slot. At most one PSEL bit is set at any time.
- PENABLE is high only in ACCESS.
- The counter clears on entering SETUP.
- PSLVERR is ignored unless PREADY=1 in ACCESS.
- A timeout and PREADY arriving in the same cycle: PREADY wins.

Decomposition:
- Package ahb_apb_bridge_pkg holds:
  - the state enum (IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2);
  - HTRANS constants (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - HRESP constants;
  - a clog2 function.
- One sub-module, apb_slot_decode: combinational HADDR -> one-hot slot vector plus unmapped flag, parametrised by NUM_SLOTS/SLOT_LSB.

Test Plan:
- Write 0xA5A5_0001 to 0x0300_0010, PREADY=1: PSEL=16'h0008 in SETUP, PENABLE the next cycle, PWDATA=0xA5A5_0001, OKAY in cycle N+4.
- Read 0x0000_0004, PREADY low 3 cycles, PRDATA=0x1234_5678: 3 extra HREADYOUT=0 cycles, then HRDATA=0x1234_5678 with OKAY.
- Write slot 2, PREADY=1 & PSLVERR=1: ERR_SLV pulse, HRESP=1/HREADYOUT=0 then HRESP=1/HREADYOUT=1, then IDLE.
- TIMEOUT_CYCLES=8, PREADY held 0: PSEL drops after 8 ACCESS cycles, ERR_TMO pulse, two-cycle ERROR.
- NUM_SLOTS=12, access to 0x0D00_0000: no PSEL bit ever set, ERR_SLV pulse, two-cycle ERROR.
- Two back-to-back NONSEQ writes, then HRESET=1 mid-ACCESS of the second: PSEL/PENABLE go to 0 and HREADYOUT to 1 asynchronously; the next transfer completes normally.
